// File: rtl/uart_tx_ctrl_if.sv
// Pop-side link between the UART byte FIFO and the transmit controller.
// The controller is the master: it decides when to pop.
interface uart_tx_ctrl_if;
   logic       have_next;  // FIFO non-empty, registered (lags pointer moves)
   logic [7:0] data;       // FIFO head byte
   logic       next;       // single-cycle pop strobe

   modport master (
      input  have_next,
      input  data,
      output next
   );

   modport slave (
      output have_next,
      output data,
      input  next
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmit controller: pops bytes from the FIFO and serialises them
// LSB first onto tx_o, one start bit, eight data bits and one stop bit.
module uart_tx_ctrl #(
   parameter int unsigned ClkFreq  = 20_000_000,
   parameter int unsigned BaudRate = 115_200
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           en_i,
   uart_tx_ctrl_if.master fifo,
   output logic           tx_o,
   output logic           busy_o
);

   localparam int unsigned Div  = ClkFreq / BaudRate;
   localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

   if (Div < 2) begin : g_div_check
      $error("uart_tx_ctrl: ClkFreq/BaudRate must be at least 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [1:0]      guard_q, guard_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            pop;
   logic            cnt_wrap;

   assign cnt_wrap = (cnt_q == CntMax);

   // Next-state, pop decision and registered-output preparation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      busy_d    = busy_q;
      pop       = 1'b0;
      // have_next is stale for two cycles after a pop; the guard masks that window
      guard_d   = (guard_q != 2'd0) ? guard_q - 2'd1 : guard_q;

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (en_i && fifo.have_next && (guard_q == 2'd0)) begin
               pop       = 1'b1;
               shift_d   = fifo.data;
               guard_d   = 2'd2;
               bit_idx_d = 3'd0;
               busy_d    = 1'b1;
               state_d   = StStart;
            end
         end
         StStart: begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_wrap) begin
               bit_idx_d = 3'd0;
               state_d   = StData;
            end
         end
         StData: begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_wrap) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_wrap) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase

      // Line level follows the state being entered so tx_o is glitch-free.
      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         guard_q   <= 2'd2;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         guard_q   <= guard_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   // Pop is suppressed while reset is held so no byte is lost to a reset.
   assign fifo.next = pop & ~reset_i;
   assign tx_o      = tx_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO model with a two-stage lagging non-empty flag,
// UART receiver model and an expected-byte scoreboard.
module tb_uart_tx_ctrl;

   localparam int Div  = 8;
   localparam int Half = Div / 2;

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   logic en = 1'b0;
   logic tx;
   logic busy;

   uart_tx_ctrl_if bus ();

   uart_tx_ctrl #(
      .ClkFreq (8),
      .BaudRate(1)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset_i),
      .en_i   (en),
      .fifo   (bus),
      .tx_o   (tx),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] push_q[$];
   int         push_rd = 0;
   logic [7:0] fifo_q[$];
   logic       occ1 = 1'b0;
   logic [7:0] exp_q[$];
   logic [8:0] rx_q[$];
   int         rx_rd = 0;
   int         pulse_t[$];
   int         viol = 0;
   int         cyc = 0;
   logic       prev_next = 1'b0;

   // FIFO model: pointer moves on the pop edge, the flag follows two edges later.
   always @(posedge clk) begin
      if (bus.next === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
      while (push_rd < push_q.size()) begin
         fifo_q.push_back(push_q[push_rd]);
         push_rd++;
      end
      occ1          <= (fifo_q.size() != 0);
      bus.have_next <= occ1;
      bus.data      <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   end

   // Pop monitor: records pop times and protocol violations.
   always @(negedge clk) begin
      cyc++;
      if (bus.next === 1'b1) begin
         pulse_t.push_back(cyc);
         if (prev_next || busy !== 1'b0) viol++;
      end
      prev_next = (bus.next === 1'b1);
   end

   // Receiver model: mid-bit sampling, stores {stop, byte}.
   logic       rx_active = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = 8'h00;
   always @(negedge clk) begin
      if (reset_i === 1'b1) rx_active = 1'b0;
      else if (!rx_active) begin
         if (tx === 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
         end
      end else rx_cnt++;
      if (rx_active && reset_i !== 1'b1) begin
         if (rx_cnt >= Div + Half && rx_cnt < 9 * Div && ((rx_cnt - Half) % Div) == 0)
            rx_byte[(rx_cnt - Half) / Div - 1] = tx;
         if (rx_cnt == 9 * Div + Half) begin
            rx_q.push_back({tx, rx_byte});
            rx_active = 1'b0;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_byte(input logic [7:0] b, input bit expect_rx);
      push_q.push_back(b);
      if (expect_rx) exp_q.push_back(b);
   endtask

   // Returns at the negedge where next is high, or ok=0 after the budget.
   task automatic wait_pulse(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.next === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int errs;
      logic [2:0] first;
      reset_i = 1'b1;
      en = 1'b1;
      tick(3);
      total++;
      if ({tx, busy, bus.next} !== 3'b100) begin
         bad++;
         $display("FAIL reset_state got {tx,busy,next}=%b want=100", {tx, busy, bus.next});
      end
      reset_i = 1'b0;
      errs = 0;
      first = 3'b100;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ({tx, busy, bus.next} !== 3'b100) begin
            if (errs == 0) first = {tx, busy, bus.next};
            errs++;
         end
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL idle_empty bad_cycles=%0d got=%b want=100", errs, first);
      end
      total++;
      if (pulse_t.size() != 0) begin
         bad++;
         $display("FAIL idle_no_pop got=%0d pops want=0", pulse_t.size());
      end
   endtask

   task automatic test_single();
      bit ok;
      int p0, errs, first_i;
      logic [9:0] fr;
      logic [8:0] got;
      logic [7:0] want;
      p0 = pulse_t.size();
      fr = {1'b1, 8'hA5, 1'b0};
      push_byte(8'hA5, 1'b1);
      wait_pulse(100, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL single_pop got=none want=pulse");
      end else begin
         errs = 0;
         first_i = -1;
         for (int i = 0; i < 10 * Div; i++) begin
            @(negedge clk);
            if (tx !== fr[i / Div] || busy !== 1'b1 || bus.next !== 1'b0) begin
               if (errs == 0) first_i = i;
               errs++;
            end
         end
         total++;
         if (errs != 0) begin
            bad++;
            $display("FAIL single_wave bad_cycles=%0d first_cycle=%0d want=0", errs, first_i);
         end
         @(negedge clk);
         total++;
         if ({tx, busy} !== 2'b10) begin
            bad++;
            $display("FAIL single_end got {tx,busy}=%b want=10", {tx, busy});
         end
      end
      tick(20);
      total++;
      if (pulse_t.size() - p0 != 1) begin
         bad++;
         $display("FAIL single_pop_count got=%0d want=1", pulse_t.size() - p0);
      end
      while (rx_rd < rx_q.size()) begin
         got = rx_q[rx_rd];
         rx_rd++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL single_rx got=%h want=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== {1'b1, want}) begin
               bad++;
               $display("FAIL single_rx got=%h want=%h", got, {1'b1, want});
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL single_rx_missing got=%0d left want=0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      logic [8:0] got;
      logic [7:0] want;
      p0 = pulse_t.size();
      push_byte(8'h00, 1'b1);
      push_byte(8'hFF, 1'b1);
      push_byte(8'h3C, 1'b1);
      tick(3 * 81 + 30);
      total++;
      if (pulse_t.size() - p0 != 3) begin
         bad++;
         $display("FAIL b2b_pop_count got=%0d want=3", pulse_t.size() - p0);
      end else begin
         for (int k = 1; k < 3; k++) begin
            total++;
            if (pulse_t[p0 + k] - pulse_t[p0 + k - 1] != 81) begin
               bad++;
               $display("FAIL b2b_spacing%0d got=%0d want=81", k,
                        pulse_t[p0 + k] - pulse_t[p0 + k - 1]);
            end
         end
      end
      while (rx_rd < rx_q.size()) begin
         got = rx_q[rx_rd];
         rx_rd++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL b2b_rx got=%h want=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== {1'b1, want}) begin
               bad++;
               $display("FAIL b2b_rx got=%h want=%h", got, {1'b1, want});
            end
         end
      end
      total++;
      if (exp_q.size() != 0 || viol != 0) begin
         bad++;
         $display("FAIL b2b_done got left=%0d viol=%0d want=0/0", exp_q.size(), viol);
      end
   endtask

   task automatic test_enable();
      bit ok;
      int p0, n;
      logic [8:0] got;
      logic [7:0] want;
      p0 = pulse_t.size();
      push_byte(8'h55, 1'b1);
      wait_pulse(100, ok);
      tick(20);
      en = 1'b0;
      push_byte(8'h81, 1'b1);
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tick(30);
      total++;
      if (pulse_t.size() - p0 != 1) begin
         bad++;
         $display("FAIL en_hold_pops got=%0d want=1", pulse_t.size() - p0);
      end
      while (rx_rd < rx_q.size()) begin
         got = rx_q[rx_rd];
         rx_rd++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL en_rx got=%h want=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== {1'b1, want}) begin
               bad++;
               $display("FAIL en_rx got=%h want=%h", got, {1'b1, want});
            end
         end
      end
      total++;
      if (exp_q.size() != 1) begin
         bad++;
         $display("FAIL en_pending got=%0d want=1", exp_q.size());
      end
      @(posedge clk);
      #1 en = 1'b1;
      #1;
      total++;
      if (bus.next !== 1'b1) begin
         bad++;
         $display("FAIL en_resume_pop got=%b want=1", bus.next);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (tx !== 1'b0) begin
         bad++;
         $display("FAIL en_resume_start got=%b want=0", tx);
      end
      tick(90);
      while (rx_rd < rx_q.size()) begin
         got = rx_q[rx_rd];
         rx_rd++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL en_rx2 got=%h want=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== {1'b1, want}) begin
               bad++;
               $display("FAIL en_rx2 got=%h want=%h", got, {1'b1, want});
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL en_rx_missing got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int pr, errs;
      logic [8:0] got;
      logic [7:0] want;
      push_byte(8'hC3, 1'b0);
      wait_pulse(100, ok);
      tick(5 * Div + 3);
      reset_i = 1'b1;
      push_byte(8'h5A, 1'b1);
      pr = pulse_t.size();
      @(negedge clk);
      total++;
      if ({tx, busy} !== 2'b10) begin
         bad++;
         $display("FAIL reset_abort got {tx,busy}=%b want=10", {tx, busy});
      end
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.next !== 1'b0 || tx !== 1'b1) errs++;
      end
      total++;
      if (errs != 0 || pulse_t.size() != pr) begin
         bad++;
         $display("FAIL reset_no_pop got bad_cycles=%0d pops=%0d want=0/0", errs,
                  pulse_t.size() - pr);
      end
      reset_i = 1'b0;
      wait_pulse(30, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL reset_recover_pop got=none want=pulse");
      end
      tick(100);
      while (rx_rd < rx_q.size()) begin
         got = rx_q[rx_rd];
         rx_rd++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL reset_rx got=%h want=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== {1'b1, want}) begin
               bad++;
               $display("FAIL reset_rx got=%h want=%h", got, {1'b1, want});
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL reset_rx_missing got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_random();
      int p0, r0, hold, n;
      logic [8:0] got;
      logic [7:0] want;
      p0 = pulse_t.size();
      r0 = rx_q.size();
      for (int i = 0; i < 32; i++) push_byte(8'($urandom), 1'b1);
      hold = 1;
      n = 0;
      while (n < 20000 && !(pulse_t.size() - p0 >= 32 && rx_q.size() - r0 >= 32)) begin
         @(posedge clk);
         #1;
         hold--;
         if (hold == 0) begin
            en = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 40);
         end
         n++;
      end
      en = 1'b1;
      tick(100);
      total++;
      if (pulse_t.size() - p0 != 32) begin
         bad++;
         $display("FAIL rand_pop_count got=%0d want=32", pulse_t.size() - p0);
      end
      while (rx_rd < rx_q.size()) begin
         got = rx_q[rx_rd];
         rx_rd++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rand_rx got=%h want=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== {1'b1, want}) begin
               bad++;
               $display("FAIL rand_rx got=%h want=%h", got, {1'b1, want});
            end
         end
      end
      total++;
      if (exp_q.size() != 0 || viol != 0) begin
         bad++;
         $display("FAIL rand_done got left=%0d viol=%0d want=0/0", exp_q.size(), viol);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Drains the UART byte FIFO and serialises each byte onto the TX line as 8N1 frames (start bit, 8 data bits LSB first, stop bit). It sits between the FIFO's pop-side interface (have-next flag, head byte, pop strobe) and the pad. It owns all pop sequencing: when to pop, when to latch data, and when to trust the FIFO's registered status again.

Parameters:
ClkFreq, 20_000_000, core clock frequency in Hz.
BaudRate, 115_200, serial bit rate in baud.
Div, ClkFreq/BaudRate (derived, localparam), clock cycles per bit. Must be >= 2; enforce with an elaboration-time check.
CntW, $clog2(Div) (derived), baud counter width.

Ports:
clk_i  in  1  core clock, all logic on rising edge.
reset_i  in  1  synchronous active-high reset.
en_i  in  1  transmit enable; when low, no new frame starts.
have_next_i  in  1  FIFO non-empty flag. Registered in the FIFO, so it lags pointer changes.
data_i  in  8  FIFO head byte, combinational from the FIFO.
next_o  out  1  single-cycle pop strobe to the FIFO.
tx_o  out  1  serial output, idle high.
busy_o  out  1  high while a frame is in flight.

Behaviour:
- Clock and reset: single clock clk_i; synchronous active-high reset_i.
- Reset values: state=IDLE, tx_o=1, next_o=0, busy_o=0, baud counter=0, bit index=0, shift register=0, guard counter=2.
- A reset asserted mid-frame aborts the frame immediately. tx_o returns to 1 on the next edge; no partial byte is retried.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If en_i && have_next_i && guard==0: assert next_o for exactly this cycle.
  - In the same cycle, latch data_i into the shift register, load guard=2, go to START.
  - busy_o is registered: it goes 1 on the IDLE->START transition and returns 0 on the STOP->IDLE transition.
- START: tx_o=0 for Div cycles, then go to DATA with bit index 0.
- DATA:
  - tx_o = shift register bit 0 for Div cycles.
  - Then shift right by 1 and increment bit index.
  - After bit index 7 completes, go to STOP.
- STOP: tx_o=1 for Div cycles, then go to IDLE.
- Bit timing: the baud counter counts 0..Div-1 and wraps; the state advances on the wrap. Every bit lasts exactly Div cycles, so a frame is exactly 10*Div cycles.
- Start latency: the start bit begins on the edge that samples the pop. tx_o falls one cycle after next_o is high.
- Guard counter:
  - Decrements by 1 each cycle while nonzero, in any state.
  - It is needed because have_next_i is stale for 2 cycles after a pop (pointer update, then flag update).
  - Because Div >= 2, the guard has always expired before the next IDLE evaluation. It is still checked explicitly for robustness.
- Back-to-back frames: if the FIFO still holds data at STOP exit, the next frame's pop happens in the first IDLE cycle. The gap between frames is 1 idle cycle, and tx_o stays 1 throughout it.
- en_i deasserted mid-frame: the current frame completes. The controller then stays in IDLE with no pop until en_i returns.
- Empty FIFO: no pop, tx_o=1, busy_o=0 indefinitely.
- next_o is never asserted outside IDLE and never for 2 consecutive cycles.
- No write-side interaction: concurrent FIFO writes only affect have_next_i.

Test Plan:
1. Reset with ClkFreq=8, BaudRate=1 (Div=8), FIFO empty, en_i=1 -> tx_o=1, busy_o=0, next_o=0 for 200 cycles.
2. Push 0xA5 -> exactly one next_o pulse. tx_o then shows 0, 1,0,1,0,0,1,0,1, then 1, each bit 8 cycles wide; busy_o is high for 80 cycles.
3. Push 0x00, 0xFF, 0x3C back-to-back -> 3 next_o pulses spaced 81 cycles apart, and decoded bytes match in order. No spurious 4th pop despite the stale have_next_i.
4. Push 0x55, then drop en_i during the DATA state -> frame 0x55 completes. No further pop while en_i=0. Raising en_i with a queued 0x81 starts the next frame on the following cycle.
5. Assert reset_i during bit 4 of 0xC3 -> tx_o=1 and busy_o=0 on the next edge. No pop occurs while reset_i is high.
6. Push 32 bytes with randomised en_i gaps -> the bench UART receiver model sees all 32 bytes in order. The total next_o count equals 32.
